sqrt_result_display: RTL and testbench
======================================

// Module: sqrt_result_display
// PURPOSE
//  Downstream display stage of the square-root finder. Captures the root on the done-stage pulse,
//  converts it to BCD with a sequential shift-add-3 engine, and drives a multiplexed
//  active-low 4-digit seven-segment display. Holds the last result until a new load arrives.
// PARAMETERS
//  DATA_W      8   width of binary root input (max value 2^DATA_W-1 must fit NUM_DIGITS digits)
//  NUM_DIGITS  4   BCD digits converted and displayed
//  REFRESH_W   17  refresh counter width; digit advances each time counter wraps to 0
// PORTS
//  clk         in   1               system clock; all logic on rising edge
//  clr_n       in   1               synchronous active-low clear
//  load        in   1               1-cycle capture strobe (driven by controller en_out)
//  result      in   DATA_W          binary root, sampled on the cycle load=1
//  busy        out  1               1 while converting
//  bcd_valid   out  1               1 when bcd holds a completed conversion
//  bcd         out  4*NUM_DIGITS    converted value, digit 0 in [3:0]
//  an          out  NUM_DIGITS      digit enables, active-low, one-hot-low
//  seg         out  7               segments {g,f,e,d,c,b,a}, active-low
//  dp          out  1               decimal point, active-low, held 1 (off)
// BEHAVIOUR
//  Reset (clr_n=0 at a rising edge, any state incl. mid-conversion): state=IDLE, busy=0,
//   bcd_valid=0, bcd=0, an=all 1s, seg=7'h7F, dp=1, refresh counter=0, digit index=0.
//  FSM states IDLE, CONVERT, SHOW.
//   IDLE: display blanked (an all 1s). load=1 -> capture result, clear BCD scratch, bit count=DATA_W, go CONVERT.
//   CONVERT: busy=1. Per cycle: add 3 to every scratch nibble >=5, then shift {scratch,shift_reg} left 1.
//    Count decrements; after DATA_W conversion cycles -> copy scratch to bcd, bcd_valid=1, go SHOW.
//    load during CONVERT ignored (no restart, no queueing).
//   SHOW: display multiplexes bcd. load=1 -> same capture as IDLE, go CONVERT; bcd_valid drops to 0
//    the cycle after load; previous bcd keeps being displayed until new result written.
//  Latency: load sampled at edge k -> busy=1 after edge k, bcd/bcd_valid updated at edge k+DATA_W+1.
//  Conversion arithmetic: scratch is 4*NUM_DIGITS bits; nibble correction combinational within the cycle;
//   no overflow for DATA_W=8/NUM_DIGITS=4 (max 0255).
//  Multiplexing: refresh counter free-running in CONVERT and SHOW; on wrap (all 1s -> 0) digit index
//   increments mod NUM_DIGITS. an[i]=0 only for i==index; seg=decode(bcd nibble index). Outputs registered.
//  Nibbles >9 (unreachable) decode to blank (7'h7F).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digits above the most significant non-zero digit are blanked
//   (an bit stays 1 in its slot); digit 0 always lit, so value 0 shows a single "0".
//  Not defined: all NUM_DIGITS digits always lit, leading zeros shown ("0025").
// STRUCTURE
//  Package sqrt_disp_pkg: state encoding (IDLE=2'b00, CONVERT=2'b01, SHOW=2'b10), SEG_BLANK=7'h7F,
//   seven-seg code constants for 0-9, DIGIT_W=4.
//  Sub-module seg7_decoder: combinational 4-bit nibble -> 7-bit active-low segment pattern.
//  Top holds FSM, shift-add-3 datapath, refresh counter, digit mux, output registers.
// TESTING (sim with REFRESH_W=4)
//  Reset then idle 20 cycles -> an=4'b1111, seg=7'h7F, busy=0, bcd_valid=0.
//  load=1, result=8'd200 -> busy=1 for 8 cycles; at edge k+9 bcd=16'h0200, bcd_valid=1, busy=0.
//  result=8'd255 in SHOW -> bcd=16'h0255; an steps 1110,1101,1011,0111 every 16 cycles,
//   seg shows 5,5,2,0 (digit 3 blanked when LEADING_ZERO_BLANK_EN defined).
//  load with 8'd99 then second load with 8'd7 three cycles later -> second ignored, bcd=16'h0099.
//  clr_n=0 for one edge at cycle 4 of a conversion -> all outputs at reset values next cycle, no bcd update.
//  result=8'd0 -> bcd=16'h0000; with LEADING_ZERO_BLANK_EN only an[0] ever goes low, seg=0 pattern.

Source files
------------

// File: rtl/sqrt_disp_pkg.sv
// Shared types and constants for the square-root result display stage:
// FSM encoding, digit width and active-low seven-segment codes {g,f,e,d,c,b,a}.
package sqrt_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CONVERT = 2'b01,
    SHOW    = 2'b10
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Codes above 9 cannot come out of the converter and decode to blank.
module seg7_decoder
  import sqrt_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  output logic [6:0]         seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (nibble)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sqrt_result_display.sv
// Captures the square-root result, converts it to BCD with shift-add-3 and multiplexes it
// onto an active-low seven-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module sqrt_result_display
  import sqrt_disp_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_W  = 17
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    load,
  input  logic [DATA_W-1:0]       result,
  output logic                    busy,
  output logic                    bcd_valid,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [1:0]              state_dbg
);

  localparam int SCR_W = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t               state, state_nxt;
  logic [DATA_W-1:0]    shift_reg;
  logic [SCR_W-1:0]     scratch, scratch_adj;
  logic [CNT_W-1:0]     cnt;
  logic [REFRESH_W-1:0] refresh;
  logic [IDX_W-1:0]     digit_idx;
  logic [DIGIT_W-1:0]   cur_nibble;
  logic [NUM_DIGITS-1:0] lit, an_nxt;
  logic [6:0]           seg_dec, seg_nxt;
  logic                 capture;

  // load is a one-cycle strobe with no ready: it is accepted in IDLE or SHOW and
  // silently dropped while a conversion is in flight.
  assign capture   = load && (state != CONVERT);
  assign busy      = (state == CONVERT) && (cnt != '0);
  assign dp        = 1'b1;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONVERT;
      CONVERT: if (cnt == '0) state_nxt = SHOW;
      SHOW:    if (load) state_nxt = CONVERT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scratch[i*DIGIT_W +: DIGIT_W] >= 4'd5)
        scratch_adj[i*DIGIT_W +: DIGIT_W] = scratch[i*DIGIT_W +: DIGIT_W] + 4'd3;
    end
  end

  // The cycle with cnt==0 is the hand-off: busy has dropped, scratch is copied out.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        shift_reg <= result;
        scratch   <= '0;
        cnt       <= CNT_INIT;
        bcd_valid <= 1'b0;
      end else if (state == CONVERT) begin
        if (cnt != '0) begin
          {scratch, shift_reg} <= {scratch_adj, shift_reg} << 1;
          cnt                  <= cnt - 1'b1;
        end else begin
          bcd       <= scratch;
          bcd_valid <= 1'b1;
        end
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen;
    seen   = 1'b0;
    lit    = '0;
    lit[0] = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] != '0) seen = 1'b1;
      lit[i] = seen;
    end
  end
`else
  assign lit = '1;
`endif

  always_comb begin
    cur_nibble = '0;
    an_nxt     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_nibble = bcd[i*DIGIT_W +: DIGIT_W];
        if (lit[i]) an_nxt[i] = 1'b0;
      end
    end
    seg_nxt = (an_nxt == '1) ? SEG_BLANK : seg_dec;
  end

  seg7_decoder u_dec (
    .nibble (cur_nibble),
    .seg_n  (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      refresh   <= '0;
      digit_idx <= '0;
      an        <= '1;
      seg       <= SEG_BLANK;
    end else if (state == IDLE) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      refresh <= refresh + 1'b1;
      if (refresh == '1)
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_sqrt_result_display.sv
// Directed bench for sqrt_result_display with a fast refresh counter; expected BCD values
// are queued at load time and popped when bcd_valid rises.
module tb_sqrt_result_display;

  localparam int DATA_W     = 8;
  localparam int NUM_DIGITS = 4;
  localparam int REFRESH_W  = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr_n, load;
  logic [7:0]  result;
  logic        busy, bcd_valid, dp;
  logic [15:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [1:0]  state_dbg;

  logic [15:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  sqrt_result_display #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_W  (REFRESH_W)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .load      (load),
    .result    (result),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .bcd       (bcd),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    r        = '0;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'(v / 100);
    return r;
  endfunction

  function automatic bit lit_model(input logic [15:0] v, input int slot);
    bit any;
    any = 1'b0;
    for (int j = slot; j < 4; j++) if (v[j*4 +: 4] != 4'd0) any = 1'b1;
    return !LZB || (slot == 0) || any;
  endfunction

  // driver: one load, then timing and result check against the queue
  task automatic run_conv(input logic [7:0] v);
    int lat, busy_cnt;
    load = 1'b1;
    result = v;
    exp_q.push_back(bcd_of(int'(v)));
    step();
    load = 1'b0;
    lat = 0;
    busy_cnt = 0;
    check("valid_drop", bcd_valid, 0);
    while (bcd_valid !== 1'b1 && lat < 30) begin
      if (busy === 1'b1) busy_cnt++;
      step();
      lat++;
    end
    check("latency", lat, 9);
    check("busy_len", busy_cnt, 8);
    check("busy_end", busy, 0);
    check("bcd", bcd, exp_q.pop_front());
  endtask

  task automatic disp_check(input logic [15:0] val);
    logic [3:0] prev, oh, ea;
    logic [6:0] es;
    int guard, s, slot, d;
    prev = an;
    guard = 0;
    while (an === prev && guard < 40) begin
      step();
      guard++;
    end
    check("disp_sync", 32'(guard < 40), 1);
    s = 0;
    for (int i = 0; i < 4; i++) begin
      oh = 4'b0001 << i;
      if (prev === ~oh) s = (i + 1) % 4;
      else if (prev === 4'hF && an === ~oh) s = i;
    end
    for (int c = 0; c < 64; c++) begin
      slot = (s + c / 16) % 4;
      d = int'(val[slot*4 +: 4]);
      oh = 4'b0001 << slot;
      if (lit_model(val, slot)) begin
        ea = ~oh;
        es = seg_tab[d];
      end else begin
        ea = 4'hF;
        es = 7'h7F;
      end
      check("disp_an", an, ea);
      check("disp_seg", seg, es);
      step();
    end
  endtask

  initial begin
    int lat;
    clr_n = 1'b0;
    load = 1'b0;
    result = '0;
    step();
    step();
    clr_n = 1'b1;

    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_busy", busy, 0);
    check("rst_valid", bcd_valid, 0);
    check("rst_bcd", bcd, 16'h0000);
    check("rst_dp", dp, 1);
    check("rst_state", state_dbg, 2'b00);
    repeat (20) step();
    check("idle_an", an, 4'hF);
    check("idle_seg", seg, 7'h7F);
    check("idle_busy", busy, 0);
    check("idle_valid", bcd_valid, 0);

    run_conv(8'd200);
    check("show_state", state_dbg, 2'b10);
    disp_check(16'h0200);

    run_conv(8'd255);
    disp_check(16'h0255);

    // second load three cycles into a conversion must be dropped
    load = 1'b1;
    result = 8'd99;
    exp_q.push_back(bcd_of(99));
    step();
    load = 1'b0;
    step();
    step();
    load = 1'b1;
    result = 8'd7;
    step();
    load = 1'b0;
    lat = 3;
    while (bcd_valid !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
    check("ign_latency", lat, 9);
    check("ign_bcd", bcd, exp_q.pop_front());
    repeat (20) step();
    check("ign_hold_bcd", bcd, 16'h0099);
    check("ign_hold_valid", bcd_valid, 1);
    check("ign_hold_busy", busy, 0);

    // clear on the fourth conversion edge
    load = 1'b1;
    result = 8'd123;
    step();
    load = 1'b0;
    check("mid_busy", busy, 1);
    step();
    step();
    step();
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bcd_valid, 0);
    check("mid_rst_bcd", bcd, 16'h0000);
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_dp", dp, 1);
    check("mid_rst_state", state_dbg, 2'b00);
    repeat (15) step();
    check("mid_no_upd_bcd", bcd, 16'h0000);
    check("mid_no_upd_valid", bcd_valid, 0);

    run_conv(8'd0);
    disp_check(16'h0000);

    for (int n = 0; n < 3; n++) run_conv(8'($urandom_range(0, 255)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
